// File: rtl/behavioural_if.sv
// behavioural_if: operand/result bundle for the behavioural gate unit.
//   master : drives a, b, in_valid; observes the eight gate results,
//            out_valid and (when BEHAVIOURAL_COVERAGE_EN is defined) the
//            coverage outputs seen_mask, all_seen, vec_count.
//   slave  : the gate unit itself (mirror directions).
// Optional feature macro: BEHAVIOURAL_COVERAGE_EN.
interface behavioural_if;
    logic       a;
    logic       b;
    logic       in_valid;
    logic       c_nota;
    logic       c_notb;
    logic       c_and;
    logic       c_or;
    logic       c_xor;
    logic       c_nand;
    logic       c_nor;
    logic       c_xnor;
    logic       out_valid;
`ifdef BEHAVIOURAL_COVERAGE_EN
    logic [3:0] seen_mask;
    logic       all_seen;
    logic [7:0] vec_count;
`endif

    modport master (
        output a, output b, output in_valid,
        input  c_nota, input c_notb, input c_and, input c_or,
        input  c_xor, input c_nand, input c_nor, input c_xnor,
        input  out_valid
`ifdef BEHAVIOURAL_COVERAGE_EN
        , input seen_mask, input all_seen, input vec_count
`endif
    );

    modport slave (
        input  a, input b, input in_valid,
        output c_nota, output c_notb, output c_and, output c_or,
        output c_xor, output c_nand, output c_nor, output c_xnor,
        output out_valid
`ifdef BEHAVIOURAL_COVERAGE_EN
        , output seen_mask, output all_seen, output vec_count
`endif
    );
endinterface

// File: rtl/behavioural.sv
// behavioural: registered two-input gate unit.
// Evaluates NOT-A, NOT-B, AND, OR, XOR, NAND, NOR, XNOR of bus.a/bus.b and
// registers them on each rising clk where bus.in_valid is high; results hold
// otherwise. bus.out_valid is in_valid delayed by one clock.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset; clears every output to 0
//   bus  - behavioural_if.slave (operands, strobe, results, coverage)
// Optional feature: define BEHAVIOURAL_COVERAGE_EN to build the truth-table
// coverage monitor (seen_mask, all_seen, saturating vec_count).
module behavioural (
    input  logic           clk,
    input  logic           rst,
    behavioural_if.slave   bus
);

    logic c_nota_d,    c_nota_q;
    logic c_notb_d,    c_notb_q;
    logic c_and_d,     c_and_q;
    logic c_or_d,      c_or_q;
    logic c_xor_d,     c_xor_q;
    logic c_nand_d,    c_nand_q;
    logic c_nor_d,     c_nor_q;
    logic c_xnor_d,    c_xnor_q;
    logic out_valid_d, out_valid_q;

    // Next-state for gate results: load on valid, otherwise hold. Operands
    // are only looked at under in_valid so junk on a/b while idle is ignored.
    always_comb begin
        c_nota_d    = c_nota_q;
        c_notb_d    = c_notb_q;
        c_and_d     = c_and_q;
        c_or_d      = c_or_q;
        c_xor_d     = c_xor_q;
        c_nand_d    = c_nand_q;
        c_nor_d     = c_nor_q;
        c_xnor_d    = c_xnor_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            c_nota_d    = ~bus.a;
            c_notb_d    = ~bus.b;
            c_and_d     = bus.a & bus.b;
            c_or_d      = bus.a | bus.b;
            c_xor_d     = bus.a ^ bus.b;
            c_nand_d    = ~(bus.a & bus.b);
            c_nor_d     = ~(bus.a | bus.b);
            c_xnor_d    = ~(bus.a ^ bus.b);
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Gate result registers; reset forces all to 0 (including the inverted
    // outputs) and wins over a coincident valid sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_nota_q    <= 1'b0;
            c_notb_q    <= 1'b0;
            c_and_q     <= 1'b0;
            c_or_q      <= 1'b0;
            c_xor_q     <= 1'b0;
            c_nand_q    <= 1'b0;
            c_nor_q     <= 1'b0;
            c_xnor_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            c_nota_q    <= c_nota_d;
            c_notb_q    <= c_notb_d;
            c_and_q     <= c_and_d;
            c_or_q      <= c_or_d;
            c_xor_q     <= c_xor_d;
            c_nand_q    <= c_nand_d;
            c_nor_q     <= c_nor_d;
            c_xnor_q    <= c_xnor_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.c_nota    = c_nota_q;
    assign bus.c_notb    = c_notb_q;
    assign bus.c_and     = c_and_q;
    assign bus.c_or      = c_or_q;
    assign bus.c_xor     = c_xor_q;
    assign bus.c_nand    = c_nand_q;
    assign bus.c_nor     = c_nor_q;
    assign bus.c_xnor    = c_xnor_q;
    assign bus.out_valid = out_valid_q;

`ifdef BEHAVIOURAL_COVERAGE_EN
    logic [3:0] seen_mask_d, seen_mask_q;
    logic [7:0] vec_count_d, vec_count_q;

    // Coverage next-state: mark the {a,b} combination and count accepted
    // vectors, saturating at 255 while the mask keeps updating.
    always_comb begin
        seen_mask_d = seen_mask_q;
        vec_count_d = vec_count_q;
        if (bus.in_valid) begin
            seen_mask_d = seen_mask_q | (4'b0001 << {bus.a, bus.b});
            if (vec_count_q != 8'hFF) begin
                vec_count_d = vec_count_q + 8'd1;
            end else begin
                vec_count_d = vec_count_q;
            end
        end else begin
            seen_mask_d = seen_mask_q;
            vec_count_d = vec_count_q;
        end
    end

    // Coverage registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_mask_q <= 4'b0000;
            vec_count_q <= 8'd0;
        end else begin
            seen_mask_q <= seen_mask_d;
            vec_count_q <= vec_count_d;
        end
    end

    assign bus.seen_mask = seen_mask_q;
    assign bus.all_seen  = &seen_mask_q;
    assign bus.vec_count = vec_count_q;
`endif

endmodule

// File: tb/tb_behavioural.sv
// Testbench for behavioural: fixed truth-table vectors, reset/hold/mid-stream
// reset sequences, and random stimulus compared with a reference model that
// derives the gate functions from operand sums.
module tb_behavioural;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    behavioural_if bus();

    behavioural dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_gates = 8'h00;
    logic       m_ov    = 1'b0;
    bit         m_seen [4];
    int         m_cnt   = 0;

    typedef struct {
        logic       a;
        logic       b;
        logic       iv;
        logic [7:0] g;   // {nota,notb,and,or,xor,nand,nor,xnor}
        logic       ov;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_gates();
        return {bus.c_nota, bus.c_notb, bus.c_and, bus.c_or,
                bus.c_xor, bus.c_nand, bus.c_nor, bus.c_xnor};
    endfunction

    // Gate functions from the count of ones among the operands.
    function automatic logic [7:0] ref_gates(input int a, input int b);
        int  s;
        logic [7:0] g;
        s = a + b;
        g[7] = (a == 0);
        g[6] = (b == 0);
        g[5] = (s == 2);
        g[4] = (s >= 1);
        g[3] = (s % 2 == 1);
        g[2] = !(s == 2);
        g[1] = !(s >= 1);
        g[0] = !(s % 2 == 1);
        return g;
    endfunction

    function automatic logic [3:0] ref_mask();
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = m_seen[i];
        return m;
    endfunction

    task automatic check_model();
        chk("gates", dut_gates(), m_gates);
        chk("out_valid", {7'd0, bus.out_valid}, {7'd0, m_ov});
`ifdef BEHAVIOURAL_COVERAGE_EN
        chk("seen_mask", {4'd0, bus.seen_mask}, {4'd0, ref_mask()});
        chk("all_seen", {7'd0, bus.all_seen}, {7'd0, logic'(ref_mask() == 4'hF)});
        chk("vec_count", bus.vec_count, 8'(m_cnt));
`endif
    endtask

    // One clock: update model from the inputs sampled at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_gates = 8'h00;
            m_ov    = 1'b0;
            for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
            m_cnt   = 0;
        end else if (bus.in_valid) begin
            m_gates = ref_gates(int'(bus.a), int'(bus.b));
            m_ov    = 1'b1;
            m_seen[2 * int'(bus.a) + int'(bus.b)] = 1'b1;
            m_cnt   = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
        end else begin
            m_ov    = 1'b0;
        end
        #1;
        check_model();
    endtask

    task automatic drive_rand(input bit force_valid);
        bus.a        = 1'($urandom_range(0, 1));
        bus.b        = 1'($urandom_range(0, 1));
        bus.in_valid = force_valid ? 1'b1 : 1'($urandom_range(0, 3) != 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
        tbl[0] = '{a:1'b0, b:1'b0, iv:1'b1, g:8'b11000111, ov:1'b1};
        tbl[1] = '{a:1'b0, b:1'b1, iv:1'b1, g:8'b10011100, ov:1'b1};
        tbl[2] = '{a:1'b1, b:1'b0, iv:1'b1, g:8'b01011100, ov:1'b1};
        tbl[3] = '{a:1'b1, b:1'b1, iv:1'b1, g:8'b00110001, ov:1'b1};
        tbl[4] = '{a:1'b0, b:1'b0, iv:1'b0, g:8'b00110001, ov:1'b0};
        tbl[5] = '{a:1'b0, b:1'b0, iv:1'b0, g:8'b00110001, ov:1'b0};
        tbl[6] = '{a:1'b0, b:1'b0, iv:1'b0, g:8'b00110001, ov:1'b0};

        // Reset held 2 clk with a valid all-ones vector present.
        rst = 1'b1; bus.a = 1'b1; bus.b = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("reset_gates", dut_gates(), 8'h00);
            chk("reset_ov", {7'd0, bus.out_valid}, 8'h00);
        end
        rst = 1'b0;

        // Truth table then hold.
        for (int i = 0; i < 7; i++) begin
            bus.a = tbl[i].a; bus.b = tbl[i].b; bus.in_valid = tbl[i].iv;
            tick();
            chk($sformatf("tbl%0d_gates", i), dut_gates(), tbl[i].g);
            chk($sformatf("tbl%0d_ov", i), {7'd0, bus.out_valid}, {7'd0, tbl[i].ov});
        end
`ifdef BEHAVIOURAL_COVERAGE_EN
        chk("tbl_seen_mask", {4'd0, bus.seen_mask}, 8'h0F);
        chk("tbl_all_seen", {7'd0, bus.all_seen}, 8'h01);
        chk("tbl_vec_count", bus.vec_count, 8'd4);
`endif

        // Random mix of valid and idle cycles.
        for (int i = 0; i < 100; i++) begin
            drive_rand(1'b0);
            tick();
        end

        // Saturation: 300 consecutive valid vectors.
        for (int i = 0; i < 300; i++) begin
            drive_rand(1'b1);
            tick();
        end
`ifdef BEHAVIOURAL_COVERAGE_EN
        chk("sat_vec_count", bus.vec_count, 8'd255);
`endif
        bus.a = 1'b0; bus.b = 1'b1; bus.in_valid = 1'b1;
        tick();
        chk("sat_gates", dut_gates(), 8'b10011100);
`ifdef BEHAVIOURAL_COVERAGE_EN
        chk("sat_hold_count", bus.vec_count, 8'd255);
`endif

        // Mid-stream reset: vector sampled in the reset cycle is discarded.
        bus.a = 1'b1; bus.b = 1'b1; bus.in_valid = 1'b1; rst = 1'b1;
        tick();
        chk("mid_rst_gates", dut_gates(), 8'h00);
        chk("mid_rst_ov", {7'd0, bus.out_valid}, 8'h00);
`ifdef BEHAVIOURAL_COVERAGE_EN
        chk("mid_rst_count", bus.vec_count, 8'd0);
`endif
        rst = 1'b0;
        bus.a = 1'b1; bus.b = 1'b0; bus.in_valid = 1'b1;
        tick();
        chk("resume_gates", dut_gates(), 8'b01011100);
        chk("resume_ov", {7'd0, bus.out_valid}, 8'h01);
        for (int i = 0; i < 40; i++) begin
            drive_rand(1'b0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
